bit_stuffer: RTL and testbench
==============================

BIT_STUFFER -- requirements
Module: bit_stuffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: bit-FIFO depth in bits; legal range is 4 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_in  input  1  serial unstuffed data bit, one per cycle.
REQ-005 SHALL have port start_stuffer  input  1  one-cycle pulse that opens a packet.
REQ-006 SHALL have port end_stuffer  input  1  one-cycle pulse that closes a packet; s_in is not sampled in that cycle.
REQ-007 SHALL have port s_out  output  1  serial stuffed bit to the NRZI encoder.
REQ-008 SHALL have port out_valid  output  1  s_out carries a packet bit this cycle.
REQ-009 SHALL have port start_encode  output  1  pulse coincident with the first valid s_out bit.
REQ-010 SHALL have port end_encode  output  1  pulse in the cycle after the last valid s_out bit.
REQ-011 SHALL have port empty  output  1  FIFO empty and output FSM in IDLE.

Function
REQ-012 Input side SHALL sample s_in on every rising edge from the edge after start_stuffer is sampled high until the edge at which end_stuffer is sampled high, exclusive of that edge.
REQ-013 start_stuffer SHALL be ignored while empty is 0.
REQ-014 end_stuffer SHALL be ignored when no packet is open.
REQ-015 Sampled bits SHALL be pushed into a DEPTH-bit FIFO in arrival order.
REQ-016 Output FSM states SHALL be IDLE, SEND, STUFF and DONE.
REQ-017 IDLE->SEND SHALL occur when the FIFO is non-empty; s_out SHALL be registered, with the first bit valid one cycle after its push.
REQ-018 In SEND, the FSM SHALL pop one bit per cycle to s_out with out_valid=1.
REQ-019 The ones counter (0..6) SHALL increment on each output 1 and clear on each output 0, whether data or stuffed.
REQ-020 When the counter reaches 6, the next cycle SHALL be STUFF: s_out=0, out_valid=1, no pop, counter cleared, then back to SEND.
REQ-021 A stuff bit SHALL be emitted even when the sixth 1 is the last data bit of the packet.
REQ-022 SEND SHALL go to DONE when the packet is closed, the FIFO is empty and no stuff is pending.
REQ-023 DONE SHALL pulse end_encode for one cycle, then go to IDLE.
REQ-024 If the FIFO goes empty mid-packet, out_valid SHALL drop, the FSM SHALL hold SEND and the counter SHALL be preserved.
REQ-025 On simultaneous push and pop, FIFO occupancy SHALL be unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-026 A push while the FIFO is full SHALL be dropped.

Reset
REQ-027 On rst_n low, outputs SHALL asynchronously take s_out=0, out_valid=0, start_encode=0, end_encode=0 and empty=1.
REQ-028 Reset SHALL set the FSM to IDLE, the FIFO pointers and ones counter to 0, and close the packet.
REQ-029 Reset mid-packet SHALL abort it without asserting end_encode; the first post-reset start_stuffer SHALL be honoured.

Configuration
REQ-030 With STUFFER_OVF_EN defined, the module SHALL add port overflow (output, 1 bit), set sticky on a dropped push and cleared only by reset or an accepted start_stuffer.
REQ-031 Without STUFFER_OVF_EN, the module SHALL have no overflow port and drops SHALL be silent.

Structure
REQ-032 Package usb_pkg SHALL hold STUFF_LIMIT=6, the stuffer FSM state enum and the default DEPTH constant.
REQ-033 The FIFO SHALL be sub-module bit_fifo: 1-bit wide, parameter DEPTH, with push, pop, dout, full and empty.

Verification
REQ-034 The bench SHALL drive start, then 11111111, then end -> s_out 111111011 over 9 out_valid cycles and end_encode the next cycle.
REQ-035 The bench SHALL drive 0101 -> s_out 0101 over 4 valid cycles with no stuff, start_encode on the first bit and end_encode after the fourth.
REQ-036 The bench SHALL drive packet 0111111 -> s_out 01111110 with the trailing stuff bit before end_encode.
REQ-037 The bench SHALL drive 111111111111 -> s_out 11111101111110, 14 bits with the counter cleared after each stuff.
REQ-038 The bench SHALL assert rst_n low after 5 bits of a 20-bit packet -> all outputs reset at once, no end_encode, and a following 0101 packet passes.
REQ-039 With STUFFER_OVF_EN and DEPTH=4, the bench SHALL drive 36 ones -> overflow=1 and held until the next accepted start_stuffer.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB bit stuffer.
// Holds the run-length limit that forces a stuffed zero, the default
// bit-FIFO depth and the output FSM state encoding.
package usb_pkg;

  // Number of consecutive 1s after which a 0 is inserted.
  localparam int STUFF_LIMIT   = 6;

  // Default bit-FIFO depth in bits.
  localparam int DEFAULT_DEPTH = 16;

  // Output FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STUFF = 2'd2,
    ST_DONE  = 2'd3
  } stuffer_state_t;

endpackage

// File: rtl/bit_fifo.sv
// 1-bit wide FIFO of DEPTH entries.
// A push is accepted when the FIFO is not full, or when it is full but a
// pop happens in the same cycle, so occupancy then stays unchanged.
// A push that cannot be accepted is silently dropped here; the parent
// decides whether to report it. Pointers wrap modulo DEPTH.
module bit_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bit_stuffer.sv
// USB bit stuffer: buffers unstuffed serial bits in a bit FIFO and emits
// them with a 0 inserted after every run of STUFF_LIMIT consecutive 1s.
// Optional macro STUFFER_OVF_EN adds a sticky 'overflow' output that flags
// a push dropped because the FIFO was full.
// Handshake: there is no back-pressure. s_in is taken every cycle while a
// packet is open; out_valid qualifies s_out in the same cycle and the
// consumer must take every valid bit.
module bit_stuffer
  import usb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_in,
  input  logic           start_stuffer,
  input  logic           end_stuffer,
  output logic           s_out,
  output logic           out_valid,
  output logic           start_encode,
  output logic           end_encode,
  output logic           empty,
`ifdef STUFFER_OVF_EN
  output logic           overflow,
`endif
  output stuffer_state_t dbg_state
);

  stuffer_state_t r_state;
  stuffer_state_t w_state_nxt;
  logic [2:0]     r_ones;
  logic           r_open;
  logic           r_s_out;
  logic           r_out_valid;
  logic           r_start_encode;

  logic       w_fifo_dout;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_start_ok;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_emit_data;
  logic [2:0] w_cnt_data;
  logic [2:0] w_cnt_nxt;
  logic       w_s_out_nxt;
  logic       w_valid_nxt;
  logic       w_start_enc_nxt;

  assign empty        = w_fifo_empty && (r_state == ST_IDLE);
  assign w_start_ok   = start_stuffer && empty;
  assign w_push_req   = r_open && !end_stuffer;
  assign w_push       = w_push_req && (!w_fifo_full || w_pop);
  assign w_emit_data  = ((r_state == ST_IDLE) || (r_state == ST_SEND)) && !w_fifo_empty;
  assign w_cnt_data   = w_fifo_dout ? (r_ones + 3'd1) : 3'd0;

  assign s_out        = r_s_out;
  assign out_valid    = r_out_valid;
  assign start_encode = r_start_encode;
  assign end_encode   = (r_state == ST_DONE);
  assign dbg_state    = r_state;

  bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (s_in),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Packet-open flag: a new start wins over an end in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= 1'b0;
    end else if (w_start_ok) begin
      r_open <= 1'b1;
    end else if (end_stuffer) begin
      r_open <= 1'b0;
    end
  end

`ifdef STUFFER_OVF_EN
  logic r_overflow;
  logic w_drop;

  assign w_drop   = w_push_req && !w_push;
  assign overflow = r_overflow;

  // Sticky drop flag, cleared by reset or by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end
`endif

  // State register plus the registered serial outputs and ones counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ones         <= 3'd0;
      r_s_out        <= 1'b0;
      r_out_valid    <= 1'b0;
      r_start_encode <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ones         <= w_cnt_nxt;
      r_s_out        <= w_s_out_nxt;
      r_out_valid    <= w_valid_nxt;
      r_start_encode <= w_start_enc_nxt;
    end
  end

  // Next state: a data bit that completes a run of 1s schedules a stuff.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = (w_cnt_data == 3'(STUFF_LIMIT)) ? ST_STUFF : ST_SEND;
        end
      end
      ST_SEND: begin
        if (!w_fifo_empty) begin
          w_state_nxt = (w_cnt_data == 3'(STUFF_LIMIT)) ? ST_STUFF : ST_SEND;
        end else if (!r_open) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_STUFF: w_state_nxt = ST_SEND;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: pop/emit a data bit, emit a stuffed 0, or hold the counter.
  always_comb begin
    w_pop           = w_emit_data;
    w_s_out_nxt     = 1'b0;
    w_valid_nxt     = 1'b0;
    w_start_enc_nxt = 1'b0;
    w_cnt_nxt       = r_ones;
    if (w_emit_data) begin
      w_s_out_nxt     = w_fifo_dout;
      w_valid_nxt     = 1'b1;
      w_start_enc_nxt = (r_state == ST_IDLE);
      w_cnt_nxt       = w_cnt_data;
    end else if (r_state == ST_STUFF) begin
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = 3'd0;
    end else if (r_state == ST_DONE) begin
      // A finished packet must not leak its trailing run into the next one.
      w_cnt_nxt = 3'd0;
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed bench for bit_stuffer. A packet-level model computes the stuffed
// bit stream for each packet; a negedge compare process checks every valid
// output bit, start_encode, empty and end_encode timing against it.
// Build with STUFFER_OVF_EN defined to also exercise the overflow flag
// (DEPTH is then 4).
module tb_bit_stuffer;
  import usb_pkg::*;

`ifdef STUFFER_OVF_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 16;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic s_in;
  logic start_stuffer;
  logic end_stuffer;
  logic s_out;
  logic out_valid;
  logic start_encode;
  logic end_encode;
  logic empty;
`ifdef STUFFER_OVF_EN
  logic overflow;
`endif
  stuffer_state_t dbg_state;

  always #5 clk = ~clk;

  bit_stuffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_in          (s_in),
    .start_stuffer (start_stuffer),
    .end_stuffer   (end_stuffer),
    .s_out         (s_out),
    .out_valid     (out_valid),
    .start_encode  (start_encode),
    .end_encode    (end_encode),
    .empty         (empty),
`ifdef STUFFER_OVF_EN
    .overflow      (overflow),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   done_cnt   = 0;
  logic first_flag = 1'b0;
  logic chk_en     = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model: bits[n-1] goes first; result packed first-bit-at-MSB.
  task automatic model_stuff(input logic [63:0] bits, input int n,
                             output logic [127:0] out, output int m);
    int ones;
    ones = 0;
    out  = '0;
    m    = 0;
    for (int i = n - 1; i >= 0; i--) begin
      out = {out[126:0], bits[i]};
      m++;
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        out = {out[126:0], 1'b0};
        m++;
        ones = 0;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (chk_en) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_bit actual=%0b required=none at %0t", s_out, $time);
          end else begin
            check("s_out", s_out, exp_q.pop_front());
          end
          check("start_encode", start_encode, first_flag);
          check("empty_busy", empty, 1'b0);
          first_flag = 1'b0;
        end else begin
          check("start_encode_idle", start_encode, 1'b0);
        end
        if (end_encode) begin
          check("end_after_last", prev_valid, 1'b1);
          check("end_drained", exp_q.size(), 0);
        end
      end
      if (end_encode) done_cnt++;
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start_stuffer = 1'b1;
    @(posedge clk); #1;
    start_stuffer = 1'b0;
`ifdef STUFFER_OVF_EN
    check("ovf_cleared_on_start", overflow, 1'b0);
`endif
  endtask

  task automatic send_packet(input logic [63:0] bits, input int n, input logic chk);
    logic [127:0] o;
    int           m;
    int           base;
    model_stuff(bits, n, o, m);
    if (chk) begin
      for (int i = m - 1; i >= 0; i--) exp_q.push_back(o[i]);
    end
    first_flag = 1'b1;
    chk_en     = chk;
    base       = done_cnt;
    pulse_start();
    for (int i = n - 1; i >= 0; i--) begin
      s_in = bits[i];
      @(posedge clk); #1;
    end
    s_in        = 1'b0;
    end_stuffer = 1'b1;
    @(posedge clk); #1;
    end_stuffer = 1'b0;
    for (int k = 0; k < 200 && done_cnt == base; k++) @(posedge clk);
    check("end_encode_count", done_cnt - base, 1);
    check("all_bits_out", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("empty_after", empty, 1'b1);
    chk_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_out"}, s_out, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_start_encode"}, start_encode, 1'b0);
    check({tag, "_end_encode"}, end_encode, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] mo;
    int           mm;
    int           base;
    logic [63:0]  long_pkt;

    rst_n         = 1'b0;
    s_in          = 1'b0;
    start_stuffer = 1'b0;
    end_stuffer   = 1'b0;
    #12;
    check_reset_outputs("reset");
    check("reset_state", dbg_state, ST_IDLE);
`ifdef STUFFER_OVF_EN
    check("reset_overflow", overflow, 1'b0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model against hand-stuffed streams.
    model_stuff(64'hFF, 8, mo, mm);
    check("model_ff", mo, 128'b111111011);
    check("model_ff_len", mm, 9);
    model_stuff(64'b0111111, 7, mo, mm);
    check("model_trailing", mo, 128'b01111110);
    model_stuff(64'hFFF, 12, mo, mm);
    check("model_12ones", mo, 128'b11111101111110);
    check("model_12ones_len", mm, 14);
    model_stuff(64'b0101, 4, mo, mm);
    check("model_0101", mo, 128'b0101);

    // Directed packets.
    send_packet(64'hFF, 8, 1'b1);
    send_packet(64'b0101, 4, 1'b1);
    send_packet(64'b0111111, 7, 1'b1);
    send_packet(64'hFFF, 12, 1'b1);
    send_packet(64'hFC3F, 16, 1'b1);
    send_packet(64'b1, 1, 1'b1);

    // Reset in the middle of a 20-bit packet.
    long_pkt = 64'hFFFFF;
    model_stuff(long_pkt, 20, mo, mm);
    for (int i = mm - 1; i >= 0; i--) exp_q.push_back(mo[i]);
    first_flag = 1'b1;
    chk_en     = 1'b1;
    base       = done_cnt;
    pulse_start();
    for (int i = 19; i >= 15; i--) begin
      s_in = long_pkt[i];
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    first_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_in  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_end_after_reset", done_cnt - base, 0);
    check("state_after_reset", dbg_state, ST_IDLE);
    send_packet(64'b0101, 4, 1'b1);

`ifdef STUFFER_OVF_EN
    // 36 ones through a 4-bit FIFO must drop bits during stuffing stalls.
    send_packet(64'hF_FFFF_FFFF, 36, 1'b0);
    check("overflow_set", overflow, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("overflow_held", overflow, 1'b1);
    send_packet(64'b0101, 4, 1'b1);
    check("overflow_after_clean", overflow, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
